sp_dma_seq: RTL and testbench
=============================

SP_DMA_SEQ -- requirements
Module: sp_dma_seq

Interface
REQ-001 Parameter AW, default 12: width of the memory-address and length registers.
REQ-002 Parameter BEAT_LG2, default 3: log2 of the beat size in bytes (8-byte beats).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 start  input  1  one-cycle request to begin a transfer.
REQ-006 addr_in  input  AW  starting byte address; bits [BEAT_LG2-1:0] are ignored.
REQ-007 len_in  input  AW  transfer length in bytes minus 1; bits [BEAT_LG2-1:0] are ignored.
REQ-008 beat_ack  input  1  the datapath accepted the current beat.
REQ-009 mem_addr  output  AW  current beat address; low BEAT_LG2 bits are always 0.
REQ-010 beat_req  output  1  a beat is pending at mem_addr.
REQ-011 beats_left  output  AW-BEAT_LG2+1  beats remaining, including the current one.
REQ-012 busy  output  1  high when the state is not IDLE, or when the pending slot is full.
REQ-013 done  output  1  one-cycle pulse after the last beat is acknowledged.
REQ-014 start_err  output  1  one-cycle pulse when a start is dropped.

Function
REQ-015 The block SHALL implement the states IDLE, XFER and DONE.
REQ-016 In IDLE, start SHALL load mem_addr and beats_left and move to XFER on the next cycle.
- mem_addr = {addr_in[AW-1:BEAT_LG2], 0}
- beats_left = len_in[AW-1:BEAT_LG2] + 1
REQ-017 beat_req SHALL be 1 exactly when the state is XFER, and SHALL be a registered output.
REQ-018 A beat SHALL complete only in a cycle where beat_req and beat_ack are both 1; beat_ack is ignored at all other times.
REQ-019 On each completed beat, mem_addr SHALL increase by 2**BEAT_LG2 modulo 2**AW (wrapping from 0xFF8 to 0x000), and beats_left SHALL decrease by 1.
REQ-020 When a beat completes with beats_left == 1, the block SHALL move to DONE; beats_left becomes 0 and mem_addr holds the post-increment value.
REQ-021 DONE SHALL last exactly one cycle, with done = 1; the next state is XFER if the pending slot is full, otherwise IDLE.
REQ-022 Latency: start to the first beat_req SHALL be 1 cycle; the last beat_ack to done SHALL be 1 cycle.
REQ-023 The maximum length, len_in = 0xFFF, SHALL give 512 beats; beats_left SHALL never overflow.
REQ-024 A start arriving in DONE or XFER SHALL be handled per REQ-030/REQ-031.
REQ-025 A start and a final beat_ack in the same cycle SHALL still be captured as a pending start, when the pending slot is enabled.

Reset
REQ-026 While reset = 1, the block SHALL enter IDLE.
REQ-027 While reset = 1, the block SHALL clear to 0: mem_addr, beats_left, beat_req, busy, done, start_err, and the pending slot.
REQ-028 Reset asserted in the middle of a transfer SHALL abandon it with no done pulse.
REQ-029 Reset SHALL take priority over start and beat_ack in the same cycle.

Configuration
REQ-030 With SP_DMA_PEND_EN defined, a start in XFER or DONE SHALL be held in a one-deep pending slot and launched in place of IDLE after DONE.
- A start arriving while the pending slot is already full SHALL be dropped, with start_err = 1.
REQ-031 Without SP_DMA_PEND_EN, any start outside IDLE SHALL be dropped, with start_err = 1, and no pending-slot logic SHALL exist.

Structure
REQ-032 The package sp_dma_pkg SHALL hold:
- the state enum (IDLE, XFER, DONE)
- default constants for AW and BEAT_LG2
REQ-033 The pending slot (address and length registers plus a valid bit) SHALL be a sub-module named sp_dma_pend, instantiated only under SP_DMA_PEND_EN.

Verification
REQ-034 Single beat: reset, then start with addr_in = 0x123 and len_in = 0x007; beat_ack held at 1.
- beat_req is 1 for one cycle with mem_addr = 0x120.
- done pulses 1 cycle after that beat.
REQ-035 Wrap: start with addr_in = 0xFF0 and len_in = 0x01F.
- Beat addresses are 0xFF0, 0xFF8, 0x000, 0x008.
- done pulses after 4 acknowledged beats.
REQ-036 Stalls: 3-beat transfer with beat_ack toggled 1,0,0,1,0,1.
- mem_addr advances only on cycles with beat_ack = 1.
- beats_left reads 3, 2, 1, 0.
REQ-037 Pending (macro on): a second start, at addr 0x400, issued during XFER.
- After the first done, beat_req reasserts with mem_addr = 0x400, and busy stays 1.
- A third start issued during XFER pulses start_err.
REQ-038 No pending (macro off): the same stimulus as REQ-037.
- start_err pulses on the second start.
- The block returns to IDLE after done.
REQ-039 Mid-transfer reset: reset for 1 cycle at beat 2 of 8.
- All outputs are 0 the next cycle, with no done pulse.
- A fresh start then works normally.

Source files
------------

// File: rtl/sp_dma_pkg.sv
// Shared types and default geometry for the single-port DMA beat sequencer.
package sp_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int AW_DEF       = 12;
  localparam int BEAT_LG2_DEF = 3;

endpackage

// File: rtl/sp_dma_seq_if.sv
// Request/beat bundle between a transfer requester (master) and sp_dma_seq (slave).
interface sp_dma_seq_if import sp_dma_pkg::*; #(
  parameter int AW       = AW_DEF,
  parameter int BEAT_LG2 = BEAT_LG2_DEF
);
  localparam int BW = AW - BEAT_LG2 + 1;

  logic          start;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] len_in;
  logic          beat_ack;
  logic [AW-1:0] mem_addr;
  logic          beat_req;
  logic [BW-1:0] beats_left;
  logic          busy;
  logic          done;
  logic          start_err;

  modport master (
    output start, addr_in, len_in, beat_ack,
    input  mem_addr, beat_req, beats_left, busy, done, start_err
  );

  modport slave (
    input  start, addr_in, len_in, beat_ack,
    output mem_addr, beat_req, beats_left, busy, done, start_err
  );

endinterface

// File: rtl/sp_dma_pend.sv
// One-deep holding slot for a start request that arrives while a transfer is running.
module sp_dma_pend #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] addr_hi_in,
  input  logic [W-1:0] len_hi_in,
  output logic         valid,
  output logic [W-1:0] addr_hi,
  output logic [W-1:0] len_hi
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      addr_hi <= '0;
      len_hi  <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      addr_hi <= addr_hi_in;
      len_hi  <= len_hi_in;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/sp_dma_seq.sv
// Beat-granular DMA address sequencer (IDLE/XFER/DONE).
// Define SP_DMA_PEND_EN to queue one start request that arrives mid-transfer.
module sp_dma_seq import sp_dma_pkg::*; #(
  parameter int AW       = AW_DEF,
  parameter int BEAT_LG2 = BEAT_LG2_DEF
) (
  input logic         clk,
  input logic         reset,
  sp_dma_seq_if.slave bus
);

  localparam int HW = AW - BEAT_LG2;
  localparam int BW = HW + 1;
  localparam logic [AW-1:0] BEAT_BYTES = AW'(2 ** BEAT_LG2);

  function automatic logic [AW-1:0] beat_addr(input logic [HW-1:0] hi);
    return {hi, {BEAT_LG2{1'b0}}};
  endfunction

  // One extra bit keeps the maximum length (all-ones + 1) from overflowing.
  function automatic logic [BW-1:0] beat_count(input logic [HW-1:0] hi);
    return {1'b0, hi} + BW'(1);
  endfunction

  state_t        state;
  logic [HW-1:0] addr_hi;
  logic [HW-1:0] len_hi;
  logic [HW-1:0] load_addr_hi;
  logic [HW-1:0] load_len_hi;
  logic          accept;
  logic          launch_start;
  logic          launch_pend;
  logic          start_drop;
  logic          load;
  logic          unused_low;

  assign addr_hi    = bus.addr_in[AW-1:BEAT_LG2];
  assign len_hi     = bus.len_in[AW-1:BEAT_LG2];
  assign unused_low = ^{bus.addr_in[BEAT_LG2-1:0], bus.len_in[BEAT_LG2-1:0]};
  assign accept     = bus.beat_req && bus.beat_ack;
  assign load       = launch_start || launch_pend;

`ifdef SP_DMA_PEND_EN
  logic          pend_valid;
  logic          pend_load;
  logic          pend_clear;
  logic [HW-1:0] pend_addr_hi;
  logic [HW-1:0] pend_len_hi;

  sp_dma_pend #(.W(HW)) u_pend (
    .clk        (clk),
    .reset      (reset),
    .load       (pend_load),
    .clear      (pend_clear),
    .addr_hi_in (addr_hi),
    .len_hi_in  (len_hi),
    .valid      (pend_valid),
    .addr_hi    (pend_addr_hi),
    .len_hi     (pend_len_hi)
  );

  // A start seen in DONE with an empty slot bypasses the slot and launches directly.
  always_comb begin
    launch_pend  = (state == DONE) && pend_valid;
    launch_start = bus.start && ((state == IDLE) || ((state == DONE) && !pend_valid));
    pend_load    = bus.start && (state == XFER) && !pend_valid;
    pend_clear   = launch_pend;
    start_drop   = bus.start && !launch_start && !pend_load;
    load_addr_hi = launch_pend ? pend_addr_hi : addr_hi;
    load_len_hi  = launch_pend ? pend_len_hi  : len_hi;
  end
`else
  always_comb begin
    launch_pend  = 1'b0;
    launch_start = bus.start && (state == IDLE);
    start_drop   = bus.start && (state != IDLE);
    load_addr_hi = addr_hi;
    load_len_hi  = len_hi;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.mem_addr   <= '0;
      bus.beats_left <= '0;
      bus.beat_req   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.start_err  <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.start_err <= start_drop;
      case (state)
        IDLE: begin
          if (load) begin
            state          <= XFER;
            bus.mem_addr   <= beat_addr(load_addr_hi);
            bus.beats_left <= beat_count(load_len_hi);
            bus.beat_req   <= 1'b1;
            bus.busy       <= 1'b1;
          end
        end
        XFER: begin
          bus.busy <= 1'b1;
          if (accept) begin
            bus.mem_addr   <= bus.mem_addr + BEAT_BYTES;
            bus.beats_left <= bus.beats_left - BW'(1);
            if (bus.beats_left == BW'(1)) begin
              state        <= DONE;
              bus.beat_req <= 1'b0;
              bus.done     <= 1'b1;
            end
          end
        end
        DONE: begin
          if (load) begin
            state          <= XFER;
            bus.mem_addr   <= beat_addr(load_addr_hi);
            bus.beats_left <= beat_count(load_len_hi);
            bus.beat_req   <= 1'b1;
            bus.busy       <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.beat_req <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_dma_seq.sv
// Scoreboard bench for sp_dma_seq: stimulus queues expected beats/done/errors, a monitor pops them.
module tb_sp_dma_seq;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sp_dma_seq_if bus ();

  sp_dma_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [9:0]  left;
  } beat_t;

  beat_t       beat_q[$];
  logic [11:0] done_q[$];
  int          err_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic push_beat(input logic [11:0] a, input logic [9:0] l);
    beat_t b;
    b.addr = a;
    b.left = l;
    beat_q.push_back(b);
  endtask

  // Caller sits just after a rising edge; returns just after the edge that sampled start.
  task automatic do_start(input logic [11:0] a, input logic [11:0] l);
    bus.start   = 1'b1;
    bus.addr_in = a;
    bus.len_in  = l;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_evt({name, "_done_timeout"}, 0);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && beat_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_evt({name, "_idle_timeout"}, beat_q.size());
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_mem_addr"},   bus.mem_addr,   0);
    chk({name, "_beats_left"}, bus.beats_left, 0);
    chk({name, "_beat_req"},   bus.beat_req,   0);
    chk({name, "_busy"},       bus.busy,       0);
    chk({name, "_done"},       bus.done,       0);
    chk({name, "_start_err"},  bus.start_err,  0);
  endtask

  always @(negedge clk) begin
    if (bus.beat_req === 1'b1 && bus.beat_ack === 1'b1) begin
      if (beat_q.size() == 0) fail_evt("beat_unexpected", bus.mem_addr);
      else begin
        beat_t e;
        e = beat_q.pop_front();
        chk("beat_addr", bus.mem_addr, e.addr);
        chk("beat_left", bus.beats_left, e.left);
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) fail_evt("done_unexpected", bus.mem_addr);
      else begin
        logic [11:0] da;
        da = done_q.pop_front();
        chk("done_addr", bus.mem_addr, da);
        chk("done_left", bus.beats_left, 0);
      end
    end
    if (bus.start_err === 1'b1) begin
      if (err_q.size() == 0) fail_evt("start_err_unexpected", 1);
      else void'(err_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_left[7];
    logic        pat[6];
    logic [11:0] a;

    exp_left = '{3, 2, 2, 2, 1, 1, 0};
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bus.start    = 1'b0;
    bus.addr_in  = '0;
    bus.len_in   = '0;
    bus.beat_ack = 1'b0;
    reset        = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single beat with ack held high
    bus.beat_ack = 1'b1;
    push_beat(12'h120, 10'd1);
    done_q.push_back(12'h128);
    do_start(12'h123, 12'h007);
    @(negedge clk);
    chk("single_first_req", bus.beat_req, 1);
    chk("single_first_addr", bus.mem_addr, 12'h120);
    wait_done("single", 10);
    chk("single_req_low_at_done", bus.beat_req, 0);
    wait_idle("single", 10);

    // Address wrap across the top of the space
    @(posedge clk);
    #1;
    push_beat(12'hFF0, 10'd4);
    push_beat(12'hFF8, 10'd3);
    push_beat(12'h000, 10'd2);
    push_beat(12'h008, 10'd1);
    done_q.push_back(12'h010);
    do_start(12'hFF0, 12'h01F);
    wait_done("wrap", 20);
    wait_idle("wrap", 10);

    // Stalled acks; ack high in IDLE must be ignored
    @(posedge clk);
    #1;
    bus.beat_ack = 1'b1;
    push_beat(12'h200, 10'd3);
    push_beat(12'h208, 10'd2);
    push_beat(12'h210, 10'd1);
    done_q.push_back(12'h218);
    do_start(12'h200, 12'h017);
    bus.beat_ack = pat[0];
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("stall_left_%0d", k), bus.beats_left, exp_left[k]);
      @(posedge clk);
      #1;
      bus.beat_ack = (k + 1 < 6) ? pat[k+1] : 1'b0;
    end
    wait_idle("stall", 10);

    // Starts issued during XFER
    @(posedge clk);
    #1;
    bus.beat_ack = 1'b0;
    push_beat(12'h300, 10'd2);
    push_beat(12'h308, 10'd1);
    done_q.push_back(12'h310);
`ifdef SP_DMA_PEND_EN
    push_beat(12'h400, 10'd1);
    done_q.push_back(12'h408);
    err_q.push_back(3);
`else
    err_q.push_back(2);
    err_q.push_back(3);
`endif
    do_start(12'h300, 12'h00F);
    do_start(12'h400, 12'h007);
    do_start(12'h500, 12'h007);
    bus.beat_ack = 1'b1;
    wait_done("pend_first", 20);
    chk("pend_busy_at_done", bus.busy, 1);
    @(negedge clk);
`ifdef SP_DMA_PEND_EN
    chk("pend_relaunch_req", bus.beat_req, 1);
    chk("pend_relaunch_addr", bus.mem_addr, 12'h400);
    chk("pend_relaunch_busy", bus.busy, 1);
`else
    chk("nopend_idle_req", bus.beat_req, 0);
    chk("nopend_idle_busy", bus.busy, 0);
`endif
    wait_idle("pend", 20);
    chk("err_q_drained", err_q.size(), 0);

    // Reset during beat 2 of 8, with a competing start in the reset cycle
    @(posedge clk);
    #1;
    bus.beat_ack = 1'b1;
    push_beat(12'h600, 10'd8);
    push_beat(12'h608, 10'd7);
    do_start(12'h600, 12'h03F);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.addr_in = 12'h700;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_still_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    push_beat(12'h7F8, 10'd2);
    push_beat(12'h800, 10'd1);
    done_q.push_back(12'h808);
    do_start(12'h7F8, 12'h008);
    wait_done("fresh", 20);
    wait_idle("fresh", 10);

    // Maximum length: 512 beats covering the whole space
    @(posedge clk);
    #1;
    a = 12'h000;
    for (int i = 0; i < 512; i++) begin
      push_beat(a, 10'(512 - i));
      a = a + 12'h008;
    end
    done_q.push_back(12'h000);
    do_start(12'h000, 12'hFFF);
    @(negedge clk);
    chk("max_first_left", bus.beats_left, 512);
    wait_done("max", 600);
    wait_idle("max", 10);

    chk("beat_q_empty", beat_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
